// File: rtl/frd_stream.sv
// Chunked ESP32 file reader: drives spi_link over Wishbone and packs the returned bytes into a
// little-endian 32-bit valid/ready stream. Define FRD_STREAM_TIMEOUT_EN for the empty-poll watchdog.
module frd_stream #(
    parameter int unsigned CHUNK_MAX    = 1024,
    parameter int unsigned TIMEOUT_LOG2 = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cmd_file_id,
    input  logic [31:0] cmd_offset,
    input  logic [23:0] cmd_len,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  wb_addr,
    output logic [31:0] wb_wdata,
    output logic [3:0]  wb_wmsk,
    output logic        wb_we,
    output logic        wb_cyc,
    input  logic [31:0] wb_rdata,
    input  logic        wb_ack,
    output logic        busy,
    output logic        err
);

    localparam int unsigned REM_W = 24;
    localparam int unsigned CNT_W = 12;

    if (CHUNK_MAX < 1 || CHUNK_MAX > 2048 || TIMEOUT_LOG2 < 1 || TIMEOUT_LOG2 > 31) begin : g_bad_cfg
        $error("frd_stream: CHUNK_MAX or TIMEOUT_LOG2 out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WR_FID, S_WR_OFS, S_WR_LEN, S_RD_DAT, S_PUSH
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   chunk_q, chunk_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        ofs_q, ofs_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [3:0]         out_keep_q, out_keep_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         wb_addr_q, wb_addr_d;
    logic [31:0]        wb_wdata_q, wb_wdata_d;
    logic               wb_we_q, wb_we_d;
    logic               wb_cyc_q, wb_cyc_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rdata_unused_c;

`ifdef FRD_STREAM_TIMEOUT_EN
    localparam int unsigned WD_W = TIMEOUT_LOG2;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdata_unused_c = ^wb_rdata[30:8];

    // Bytes requested in one ESP32 read: bounded by the spi_link FIFO depth.
    function automatic logic [CNT_W-1:0] chunk_of(input logic [REM_W-1:0] rem);
        if (rem < REM_W'(CHUNK_MAX)) return rem[CNT_W-1:0];
        return CNT_W'(CHUNK_MAX);
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        chunk_d     = chunk_q;
        lane_d      = lane_q;
        ofs_d       = ofs_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
`ifdef FRD_STREAM_TIMEOUT_EN
        err_d       = err_q;
        wd_d        = wd_q;
`endif
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                remaining_d = cmd_len;
                ofs_d       = cmd_offset;
                lane_d      = 2'd0;
                out_data_d  = 32'd0;
`ifdef FRD_STREAM_TIMEOUT_EN
                err_d       = 1'b0;
                wd_d        = '0;
`endif
                if (cmd_len != 24'd0) state_d = S_WR_FID;
            end
            S_WR_FID: if (wb_ack) state_d = S_WR_OFS;
            S_WR_OFS: if (wb_ack) state_d = S_WR_LEN;
            S_WR_LEN: if (wb_ack) begin
                chunk_d = chunk_of(remaining_q);
                state_d = S_RD_DAT;
            end
            S_RD_DAT: if (wb_ack) begin
                if (wb_rdata[31]) begin
                    out_data_d[{lane_q, 3'b000} +: 8] = wb_rdata[7:0];
                    chunk_d     = chunk_q - 12'd1;
                    remaining_d = remaining_q - 24'd1;
                    lane_d      = lane_q + 2'd1;
`ifdef FRD_STREAM_TIMEOUT_EN
                    wd_d        = '0;
`endif
                    // Chunk boundaries never flush a partial word; only word-full or end-of-command do.
                    if (lane_q == 2'd3 || remaining_q == 24'd1) begin
                        state_d     = S_PUSH;
                        out_valid_d = 1'b1;
                        out_last_d  = (remaining_q == 24'd1);
                        out_keep_d  = {lane_q == 2'd3, lane_q >= 2'd2, lane_q != 2'd0, 1'b1};
                    end else if (chunk_q == 12'd1) begin
                        state_d = S_WR_LEN;
                    end
                end
`ifdef FRD_STREAM_TIMEOUT_EN
                else if (wd_q == {WD_W{1'b1}}) begin
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                    lane_d     = 2'd0;
                    out_data_d = 32'd0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_PUSH: if (out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_keep_d  = 4'd0;
                out_data_d  = 32'd0;
                lane_d      = 2'd0;
                if (remaining_q == 24'd0)  state_d = S_IDLE;
                else if (chunk_q == 12'd0) state_d = S_WR_LEN;
                else                       state_d = S_RD_DAT;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs follow the next state so each access is presented from its first cycle.
        wb_cyc_d   = 1'b0;
        wb_we_d    = 1'b0;
        wb_addr_d  = 3'd0;
        wb_wdata_d = 32'd0;
        case (state_d)
            S_WR_FID: begin
                wb_cyc_d   = 1'b1;
                wb_we_d    = 1'b1;
                wb_addr_d  = 3'd1;
                wb_wdata_d = (state_q == S_IDLE) ? cmd_file_id : wb_wdata_q;
            end
            S_WR_OFS: begin
                wb_cyc_d   = 1'b1;
                wb_we_d    = 1'b1;
                wb_addr_d  = 3'd2;
                wb_wdata_d = ofs_d;
            end
            S_WR_LEN: begin
                wb_cyc_d   = 1'b1;
                wb_we_d    = 1'b1;
                wb_addr_d  = 3'd3;
                wb_wdata_d = 32'(chunk_of(remaining_d) - 12'd1);
            end
            S_RD_DAT: begin
                wb_cyc_d  = 1'b1;
                wb_addr_d = 3'd4;
            end
            default: ;
        endcase
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            chunk_q     <= '0;
            lane_q      <= 2'd0;
            ofs_q       <= 32'd0;
            out_data_q  <= 32'd0;
            out_keep_q  <= 4'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            wb_addr_q   <= 3'd0;
            wb_wdata_q  <= 32'd0;
            wb_we_q     <= 1'b0;
            wb_cyc_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef FRD_STREAM_TIMEOUT_EN
            err_q       <= 1'b0;
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            lane_q      <= lane_d;
            ofs_q       <= ofs_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_we_q     <= wb_we_d;
            wb_cyc_q    <= wb_cyc_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef FRD_STREAM_TIMEOUT_EN
            err_q       <= err_d;
            wd_q        <= wd_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign wb_addr   = wb_addr_q;
    assign wb_wdata  = wb_wdata_q;
    assign wb_wmsk   = 4'hF;
    assign wb_we     = wb_we_q;
    assign wb_cyc    = wb_cyc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_frd_stream.sv
// Scoreboard bench for frd_stream: spi_link bus model, random byte streams and a word-level model.
module tb_frd_stream;
    localparam int unsigned CHUNK = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd_file_id = '0;
    logic [31:0] cmd_offset = '0;
    logic [23:0] cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_wmsk;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic        busy;
    logic        err;

    frd_stream #(.CHUNK_MAX(CHUNK), .TIMEOUT_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_file_id(cmd_file_id), .cmd_offset(cmd_offset), .cmd_len(cmd_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we), .wb_cyc(wb_cyc),
        .wb_rdata(wb_rdata), .wb_ack(wb_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
    typedef struct { logic [2:0] addr; logic [31:0] data; } wr_t;

    word_t      exp_words[$];
    wr_t        exp_wr[$];
    logic [7:0] src[$];
    int n_checks = 0;
    int n_errors = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    int empty_polls = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // spi_link bus model: ack one cycle after each access starts; data register stalls stall_n polls per byte.
    wr_t        s_wr;
    logic [7:0] s_byte;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= 32'd0;
        end else if (wb_cyc && !wb_ack) begin
            wb_ack <= 1'b1;
            check("wb_wmsk", 64'(wb_wmsk), 64'(4'hF));
            if (wb_we) begin
                wb_rdata <= 32'd0;
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h", wb_addr, wb_wdata);
                end else begin
                    s_wr = exp_wr.pop_front();
                    check("wr_addr", 64'(wb_addr), 64'(s_wr.addr));
                    check("wr_data", 64'(wb_wdata), 64'(s_wr.data));
                end
            end else begin
                check("rd_addr", 64'(wb_addr), 64'(3'd4));
                if (src.size() > 0 && stall_cnt >= stall_n) begin
                    s_byte = src.pop_front();
                    wb_rdata <= {1'b1, 23'h2A5A5A, s_byte};
                    stall_cnt = 0;
                end else begin
                    wb_rdata <= 32'h7FFF_FF5A;
                    stall_cnt++;
                    empty_polls++;
                end
            end
        end else begin
            wb_ack <= 1'b0;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every handshake.
    word_t      m_w;
    logic [31:0] hold_data;
    logic [3:0]  hold_keep;
    logic        hold_pend = 1'b0;
    logic        idle_chk = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (idle_chk) begin
                check("idle_after_last", 64'({busy, cmd_ready}), 64'(2'b01));
                idle_chk = 1'b0;
            end
            if (hold_pend) begin
                check("push_stable", 64'({out_valid, out_keep, out_data}), 64'({1'b1, hold_keep, hold_data}));
                hold_pend = 1'b0;
            end
            if (out_valid) begin
                check("no_bus_in_push", 64'(wb_cyc), 64'(0));
                if (out_ready) begin
                    if (exp_words.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: data %0h keep %0h", out_data, out_keep);
                    end else begin
                        m_w = exp_words.pop_front();
                        check("out_data", 64'(out_data), 64'(m_w.data));
                        check("out_keep", 64'(out_keep), 64'(m_w.keep));
                        check("out_last", 64'(out_last), 64'(m_w.last));
                    end
                    if (out_last) idle_chk = 1'b1;
                end else begin
                    hold_pend = 1'b1;
                    hold_data = out_data;
                    hold_keep = out_keep;
                end
            end
        end
    end

    // Reference: bytes group four per word from lane 0; one length write per chunk of up to CHUNK bytes.
    task automatic issue(input logic [31:0] fid, input logic [31:0] ofs, input int len,
                         input bit seq, input bit nodata);
        logic [7:0] b[$];
        int nw, r, c, t;
        word_t w;
        for (int i = 0; i < len; i++) b.push_back(seq ? 8'(i + 1) : 8'($urandom));
        if (len > 0) begin
            exp_wr.push_back('{3'd1, fid});
            exp_wr.push_back('{3'd2, ofs});
            r = len;
            while (r > 0) begin
                c = (r < int'(CHUNK)) ? r : int'(CHUNK);
                exp_wr.push_back('{3'd3, 32'(c - 1)});
                r -= c;
            end
        end
        if (!nodata) begin
            nw = (len + 3) / 4;
            for (int wi = 0; wi < nw; wi++) begin
                w.data = 32'd0;
                w.keep = 4'd0;
                for (int k = 0; k < 4; k++) begin
                    if (4 * wi + k < len) begin
                        w.data[8*k +: 8] = b[4*wi + k];
                        w.keep[k] = 1'b1;
                    end
                end
                w.last = (wi == nw - 1);
                exp_words.push_back(w);
            end
            foreach (b[i]) src.push_back(b[i]);
        end
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        cmd_file_id = fid;
        cmd_offset  = ofs;
        cmd_len     = 24'(len);
        cmd_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (len > 0)
            check("accept_to_cyc", 64'({wb_cyc, wb_addr, busy, cmd_ready}), 64'({1'b1, 3'd1, 1'b1, 1'b0}));
        else
            check("len0_idle", 64'({wb_cyc, busy, cmd_ready}), 64'(3'b001));
    endtask

    task automatic wait_done(input int budget);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
            done = (exp_words.size() == 0) && (exp_wr.size() == 0) && cmd_ready && !busy;
        end
        check("done_in_time", 64'(done), 64'(1));
        check("src_drained", 64'(src.size()), 64'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p0;
        int t;
        bit ok;
        logic [31:0] d0;
        logic [3:0]  k0;

        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({wb_cyc, wb_we, out_valid, out_last, busy, err, cmd_ready}), 64'(7'b0000001));
        check("rst_data", 64'({wb_addr, out_data, out_keep}), 64'(0));
        rst_n = 1'b1;

        issue(32'd7, 32'h100, 8, 1'b1, 1'b0);
        wait_done(500);
        issue(32'd3, 32'h20, 5, 1'b1, 1'b0);
        wait_done(500);

        issue(32'd9, 32'd0, 0, 1'b0, 1'b0);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (wb_cyc || busy || out_valid || !cmd_ready) ok = 1'b0;
        end
        check("len0_quiet", 64'(ok), 64'(1));

        ready_mode = 1;
        issue(32'h55, 32'h1234, 2500, 1'b0, 1'b0);
        wait_done(20000);

        ready_mode = 0;
        stall_n = 10;
        p0 = empty_polls;
        issue(32'd4, 32'h40, 6, 1'b0, 1'b0);
        wait_done(2000);
        check("retries", 64'(empty_polls - p0), 64'(60));
        stall_n = 0;
        check("err_idle", 64'(err), 64'(0));

        ready_mode = 2;
        issue(32'd5, 32'h80, 4, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_reached", 64'(out_valid), 64'(1));
        d0 = out_data;
        k0 = out_keep;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wb_cyc || !out_valid || out_data !== d0 || out_keep !== k0) ok = 1'b0;
        end
        check("hold20", 64'(ok), 64'(1));
        ready_mode = 0;
        wait_done(500);

        ready_mode = 1;
        for (int n = 0; n < 6; n++) begin
            stall_n = $urandom_range(0, 3);
            issue($urandom, $urandom, $urandom_range(1, 40), 1'b0, 1'b0);
            repeat (3) @(negedge clk);
            if (busy) begin
                cmd_file_id = 32'hDEAD;
                cmd_offset  = 32'hBEEF;
                cmd_len     = 24'd3;
                cmd_valid   = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            wait_done(5000);
        end
        stall_n = 0;
        ready_mode = 0;

`ifdef FRD_STREAM_TIMEOUT_EN
        p0 = empty_polls;
        issue(32'd11, 32'd0, 4, 1'b0, 1'b1);
        t = 0;
        while (!err && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wd_err", 64'(err), 64'(1));
        check("wd_polls", 64'(empty_polls - p0), 64'(16));
        check("wd_idle", 64'({cmd_ready, busy, wb_cyc, out_valid, out_last}), 64'(5'b10000));
        issue(32'd12, 32'd8, 4, 1'b0, 1'b0);
        check("err_cleared", 64'(err), 64'(0));
        wait_done(500);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
